// File: rtl/mem_rtl_pkg.sv
// Shared definitions for the multi-port memory and its init sequencer.
//   RD_FIRST / WR_THROUGH : encodings for the RD_MODE parameter
//   init_state_e          : init sequencer states
package mem_rtl_pkg;

    localparam int unsigned RD_FIRST   = 0;  // collision returns the pre-write word
    localparam int unsigned WR_THROUGH = 1;  // collision returns the merged word

    typedef enum logic {
        StInit,
        StReady
    } init_state_e;

endpackage

// File: rtl/mem_rtl_init_ctr.sv
// Post-reset clearing sequencer: walks every address once, writing zero.
// Ports:
//   clk      in   sole clock, rising edge
//   rst_n    in   synchronous active-low reset
//   busy     out  high while clearing (and throughout reset when INIT_ZERO)
//   clr_en   out  clear-write strobe for the array
//   clr_addr out  address being cleared
module mem_rtl_init_ctr
    import mem_rtl_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 1024,
    parameter int unsigned INIT_ZERO = 1,
    parameter int unsigned AW        = $clog2(NUM_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          busy,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LastAddr = AW'(NUM_WORDS - 1);

    init_state_e   state_q, state_d;
    logic [AW-1:0] ctr_q, ctr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= (INIT_ZERO != 0) ? StInit : StReady;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    end

    // The counter parks on the last address rather than wrapping.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        unique case (state_q)
            StInit: begin
                if (ctr_q == LastAddr) begin
                    state_d = StReady;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: begin
                state_d = StReady;
            end
        endcase
    end

    // Clearing is held off while reset is asserted so reset alone never touches the array.
    always_comb begin
        busy     = rst_n ? (state_q == StInit) : (INIT_ZERO != 0);
        clr_en   = rst_n && (state_q == StInit);
        clr_addr = ctr_q;
    end

endmodule

// File: rtl/mem_rtl_nport.sv
// Single-clock memory with one read/write port (port 0) and NUM_RPORTS read-only ports.
// Requests are registered on one edge and the array is accessed on the next (2-cycle latency).
// Ports:
//   clk, rst_n             clock and synchronous active-low reset
//   IN_nce/IN_nwe          port-0 enable / write enable (active-low)
//   IN_addr/IN_data/IN_wm  port-0 address, write data, byte write mask
//   OUT_data               port-0 read data
//   IN_nce1/IN_addr1       read-port enables (active-low) and packed addresses
//   OUT_data1              packed read-port data
//   OUT_valid              read-data-valid strobes, bit 0 = port 0
//   OUT_busy               post-reset clearing in progress
module mem_rtl_nport
    import mem_rtl_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned NUM_WORDS  = 1024,
    parameter int unsigned NUM_RPORTS = 2,
    parameter int unsigned RD_MODE    = 0,
    parameter int unsigned INIT_ZERO  = 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      IN_nce,
    input  logic                                      IN_nwe,
    input  logic [$clog2(NUM_WORDS)-1:0]              IN_addr,
    input  logic [WORD_SIZE-1:0]                      IN_data,
    input  logic [WORD_SIZE/8-1:0]                    IN_wm,
    output logic [WORD_SIZE-1:0]                      OUT_data,
    input  logic [NUM_RPORTS-1:0]                     IN_nce1,
    input  logic [NUM_RPORTS*$clog2(NUM_WORDS)-1:0]   IN_addr1,
    output logic [NUM_RPORTS*WORD_SIZE-1:0]           OUT_data1,
    output logic [NUM_RPORTS:0]                       OUT_valid,
    output logic                                      OUT_busy
);

    localparam int unsigned AW = $clog2(NUM_WORDS);
    localparam int unsigned NB = WORD_SIZE / 8;

    logic [WORD_SIZE-1:0] mem [NUM_WORDS];

    logic          busy;
    logic          clr_en;
    logic [AW-1:0] clr_addr;

    mem_rtl_init_ctr #(
        .NUM_WORDS (NUM_WORDS),
        .INIT_ZERO (INIT_ZERO),
        .AW        (AW)
    ) u_init_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy     (busy),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    // Request stage.
    logic                       nce_q, nwe_q;
    logic [AW-1:0]              addr_q;
    logic [WORD_SIZE-1:0]       data_q;
    logic [NB-1:0]              wm_q;
    logic [NUM_RPORTS-1:0]      rd_nce_q;
    logic [NUM_RPORTS*AW-1:0]   rd_addr_q;

    // Requests arriving while busy are dropped, never queued.
    always_ff @(posedge clk) begin
        if (!rst_n || busy) begin
            nce_q    <= 1'b1;
            nwe_q    <= 1'b1;
            rd_nce_q <= '1;
        end else begin
            nce_q    <= IN_nce;
            nwe_q    <= IN_nwe;
            rd_nce_q <= IN_nce1;
        end
    end

    always_ff @(posedge clk) begin
        addr_q    <= IN_addr;
        data_q    <= IN_data;
        wm_q      <= IN_wm;
        rd_addr_q <= IN_addr1;
    end

    // Access stage.
    logic                  access_ok;
    logic                  wr_en;
    logic                  rd0_en;
    logic [NUM_RPORTS-1:0] rd_en;
    logic [WORD_SIZE-1:0]  wr_mask;
    logic [WORD_SIZE-1:0]  rd_word [NUM_RPORTS];

    always_comb begin
        access_ok = rst_n && !busy;
        wr_en     = access_ok && !nce_q && !nwe_q;
        rd0_en    = access_ok && !nce_q && nwe_q;
        for (int k = 0; k < NUM_RPORTS; k++) begin
            rd_en[k] = access_ok && !rd_nce_q[k];
        end
        for (int b = 0; b < NB; b++) begin
            wr_mask[b*8 +: 8] = {8{wm_q[b]}};
        end
    end

    // Read-port data; in write-through mode a same-address write is merged in bytewise.
    always_comb begin
        for (int k = 0; k < NUM_RPORTS; k++) begin
            rd_word[k] = mem[rd_addr_q[k*AW +: AW]];
            if (RD_MODE == WR_THROUGH && wr_en && rd_addr_q[k*AW +: AW] == addr_q) begin
                rd_word[k] = (rd_word[k] & ~wr_mask) | (data_q & wr_mask);
            end
        end
    end

    // Array has no reset; only the init sequencer clears it.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wm_q[b]) begin
                    mem[addr_q][b*8 +: 8] <= data_q[b*8 +: 8];
                end
            end
        end
    end

    logic [WORD_SIZE-1:0]            out_data_q;
    logic [NUM_RPORTS*WORD_SIZE-1:0] out_data1_q;
    logic [NUM_RPORTS:0]             out_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_data1_q <= '0;
            out_valid_q <= '0;
        end else begin
            out_valid_q[0] <= rd0_en;
            if (rd0_en) begin
                out_data_q <= mem[addr_q];
            end
            for (int k = 0; k < NUM_RPORTS; k++) begin
                out_valid_q[k+1] <= rd_en[k];
                if (rd_en[k]) begin
                    out_data1_q[k*WORD_SIZE +: WORD_SIZE] <= rd_word[k];
                end
            end
        end
    end

    assign OUT_data  = out_data_q;
    assign OUT_data1 = out_data1_q;
    assign OUT_valid = out_valid_q;
    assign OUT_busy  = busy;

endmodule
